// File: rtl/pll_sup_pkg.sv
// Shared types for the PLL lock supervisor: sequencer state encoding and
// the sizing function for the shared cycle counter.
package pll_sup_pkg;

  typedef enum logic [1:0] {
    PLL_RESET = 2'd0,
    WAIT_LOCK = 2'd1,
    SETTLE    = 2'd2,
    RUN       = 2'd3
  } sup_state_e;

  // One counter serves every state, so it is sized for the longest interval.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync_ff.sv
// Multi-stage bit synchronizer with asynchronous active-low reset to 0.
module sync_ff #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer and lock supervisor; gates the system reset on settled lock.
// Define LOCK_LOSS_COUNT_EN to build the saturating lock-loss event counter.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned LOCK_TIMEOUT  = 65536,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       reinit_req,
  output logic       pll_rst,
  output logic       sys_reset_n,
  output logic       ready,
  output logic       timeout_err,
  output logic [7:0] loss_count
);

  localparam int unsigned CW = cnt_width(RST_CYCLES, SETTLE_CYCLES, LOCK_TIMEOUT);
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT - 1);
  // The lock sample that moves WAIT_LOCK into SETTLE is the first of the run.
  localparam logic [CW-1:0] SET_LAST = CW'((SETTLE_CYCLES >= 2) ? SETTLE_CYCLES - 2 : 0);

  sup_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pll_rst_q, pll_rst_d;
  logic          sys_reset_n_q, sys_reset_n_d;
  logic          ready_q, ready_d;
  logic          timeout_err_q, timeout_err_d;
  logic          lock_s;

  sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lock_s)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + CW'(1);
    timeout_err_d = timeout_err_q;
    if (reinit_req) begin
      state_d = PLL_RESET;
      cnt_d   = '0;
    end else begin
      case (state_q)
        PLL_RESET: begin
          if (cnt_q == RST_LAST) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_d = (SETTLE_CYCLES == 1) ? RUN : SETTLE;
            cnt_d   = '0;
          end else if (cnt_q == TMO_LAST) begin
            state_d       = PLL_RESET;
            cnt_d         = '0;
            timeout_err_d = 1'b1;
          end
        end
        SETTLE: begin
          if (!lock_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == SET_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
          end
        end
        RUN: begin
          cnt_d = cnt_q;
          if (!lock_s) begin
            state_d = PLL_RESET;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = PLL_RESET;
          cnt_d   = '0;
        end
      endcase
    end
    pll_rst_d     = (state_d == PLL_RESET);
    sys_reset_n_d = (state_d == RUN);
    ready_d       = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= PLL_RESET;
      cnt_q         <= '0;
      pll_rst_q     <= 1'b1;
      sys_reset_n_q <= 1'b0;
      ready_q       <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pll_rst_q     <= pll_rst_d;
      sys_reset_n_q <= sys_reset_n_d;
      ready_q       <= ready_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign pll_rst     = pll_rst_q;
  assign sys_reset_n = sys_reset_n_q;
  assign ready       = ready_q;
  assign timeout_err = timeout_err_q;

`ifdef LOCK_LOSS_COUNT_EN
  logic [7:0] loss_count_q, loss_count_d;
  logic       lock_lost;

  // A reinit request wins over lock loss, so it is not counted as one.
  assign lock_lost = !reinit_req && (state_q == RUN) && !lock_s;

  always_comb begin
    loss_count_d = loss_count_q;
    if (lock_lost && (loss_count_q != 8'hFF)) loss_count_d = loss_count_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) loss_count_q <= '0;
    else        loss_count_q <= loss_count_d;
  end

  assign loss_count = loss_count_q;
`else
  assign loss_count = '0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor with short settle/timeout values.
`timescale 1ns/1ps
module tb_pll_lock_supervisor;

  localparam int unsigned RST = 16;
  localparam int unsigned SET = 32;
  localparam int unsigned TMO = 100;
  localparam int unsigned SYN = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       reinit_req = 1'b0;
  logic       pll_rst, sys_reset_n, ready, timeout_err;
  logic [7:0] loss_count;

  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  typedef struct {
    string       tag;
    int unsigned at;
    logic [3:0]  flags;  // {pll_rst, sys_reset_n, ready, timeout_err}
    logic [7:0]  lc;
  } exp_t;

  exp_t sb[$];

  pll_lock_supervisor #(
    .RST_CYCLES    (RST),
    .SETTLE_CYCLES (SET),
    .LOCK_TIMEOUT  (TMO),
    .SYNC_STAGES   (SYN)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_locked  (pll_locked),
    .reinit_req  (reinit_req),
    .pll_rst     (pll_rst),
    .sys_reset_n (sys_reset_n),
    .ready       (ready),
    .timeout_err (timeout_err),
    .loss_count  (loss_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [7:0] lc_after(input int unsigned k);
`ifdef LOCK_LOSS_COUNT_EN
    return (k > 255) ? 8'hFF : 8'(k);
`else
    return 8'h00;
`endif
  endfunction

  task automatic expect_at(input string tag, input int unsigned at,
                           input logic pr, input logic srn, input logic rdy,
                           input logic te, input logic [7:0] lc);
    exp_t e;
    e.tag   = tag;
    e.at    = at;
    e.flags = {pr, srn, rdy, te};
    e.lc    = lc;
    sb.push_back(e);
  endtask

  task automatic wait_until(input int unsigned c);
    while (cyc < c) @(negedge clk);
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        check({sb[i].tag, ".flags"}, 32'({pll_rst, sys_reset_n, ready, timeout_err}),
              32'(sb[i].flags));
        check({sb[i].tag, ".loss_count"}, 32'(loss_count), 32'(sb[i].lc));
        sb.delete(i);
      end else if (sb[i].at < cyc) begin
        check({sb[i].tag, ".missed_cycle"}, cyc, sb[i].at);
        sb.delete(i);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got time %0t, expected completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned r, l, g, d, f;
    logic [7:0]  lc1;
    lc1 = lc_after(1);

    // Power-up and first lock
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check("reset.flags", 32'({pll_rst, sys_reset_n, ready, timeout_err}), 32'h8);
    check("reset.loss_count", 32'(loss_count), 32'h0);
    rst_n = 1'b1;
    r = cyc;
    expect_at("pu_rst_first", r + 1,  1, 0, 0, 0, 8'h00);
    expect_at("pu_rst_last",  r + 15, 1, 0, 0, 0, 8'h00);
    expect_at("pu_rst_end",   r + 16, 0, 0, 0, 0, 8'h00);
    wait_until(r + 40);
    pll_locked = 1'b1;
    expect_at("pu_settle_end", r + 73, 0, 0, 0, 0, 8'h00);
    expect_at("pu_run",        r + 74, 0, 1, 1, 0, 8'h00);

    // Lock loss in RUN
    wait_until(r + 80);
    l = cyc;
    pll_locked = 1'b0;
    expect_at("loss_still_run", l + 2,  0, 1, 1, 0, 8'h00);
    expect_at("loss_reset",     l + 3,  1, 0, 0, 0, lc1);
    expect_at("loss_rst_last",  l + 18, 1, 0, 0, 0, lc1);
    expect_at("loss_rst_end",   l + 19, 0, 0, 0, 0, lc1);

    // Glitch in SETTLE restarts the settle interval
    wait_until(l + 30);
    g = cyc;
    pll_locked = 1'b1;
    wait_until(g + 22);
    d = cyc;
    pll_locked = 1'b0;
    expect_at("glitch_no_early_run", d + 12, 0, 0, 0, 0, lc1);
    expect_at("glitch_settle_end",   d + 36, 0, 0, 0, 0, lc1);
    expect_at("glitch_run",          d + 37, 0, 1, 1, 0, lc1);
    wait_until(d + 3);
    pll_locked = 1'b1;

    // reinit coinciding with lock_s fall, then reinit extending the pulse
    wait_until(d + 45);
    f = cyc;
    pll_locked = 1'b0;
    expect_at("reinit_still_run", f + 2, 0, 1, 1, 0, lc1);
    expect_at("reinit_reset",     f + 3, 1, 0, 0, 0, lc1);
    wait_until(f + 2);
    reinit_req = 1'b1;
    wait_until(f + 3);
    reinit_req = 1'b0;
    wait_until(f + 10);
    reinit_req = 1'b1;
    expect_at("extend_past_normal", f + 19, 1, 0, 0, 0, lc1);
    expect_at("extend_last",        f + 26, 1, 0, 0, 0, lc1);
    expect_at("extend_end",         f + 27, 0, 0, 0, 0, lc1);
    wait_until(f + 11);
    reinit_req = 1'b0;

    // Timeout with lock held low, repeating
    expect_at("tmo_before",     f + 126, 0, 0, 0, 0, lc1);
    expect_at("tmo_first",      f + 127, 1, 0, 0, 1, lc1);
    expect_at("tmo_rst_last",   f + 142, 1, 0, 0, 1, lc1);
    expect_at("tmo_rst_end",    f + 143, 0, 0, 0, 1, lc1);
    expect_at("tmo_2nd_before", f + 242, 0, 0, 0, 1, lc1);
    expect_at("tmo_second",     f + 243, 1, 0, 0, 1, lc1);

    // Asynchronous reset mid-SETTLE
    wait_until(f + 250);
    pll_locked = 1'b1;
    expect_at("async_pre_settle", f + 274, 0, 0, 0, 1, lc1);
    wait_until(f + 275);
    rst_n = 1'b0;
    #1;
    check("async.flags", 32'({pll_rst, sys_reset_n, ready, timeout_err}), 32'h8);
    check("async.loss_count", 32'(loss_count), 32'h0);
    #2;
    rst_n = 1'b1;
    r = cyc;
    expect_at("async_rst_last", r + 15, 1, 0, 0, 0, 8'h00);
    expect_at("async_rst_end",  r + 16, 0, 0, 0, 0, 8'h00);
    expect_at("async_settle",   r + 47, 0, 0, 0, 0, 8'h00);
    expect_at("async_run",      r + 48, 0, 1, 1, 0, 8'h00);

    // Repeated lock losses drive the counter into saturation
    wait_until(r + 50);
    for (int unsigned k = 1; k <= 260; k++) begin
      f = cyc;
      pll_locked = 1'b0;
      expect_at($sformatf("sat_loss%0d", k), f + 3,  1, 0, 0, 0, lc_after(k));
      expect_at($sformatf("sat_run%0d", k),  f + 51, 0, 1, 1, 0, lc_after(k));
      wait_until(f + 1);
      pll_locked = 1'b1;
      wait_until(f + 52);
    end

    wait_until(cyc + 5);
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
